// File: rtl/stack_sequencer.sv
// stack_sequencer: multi-cycle controller for the stack processor datapath.
// Fetches opcodes from a combinational instruction memory, sequences a
// single-port synchronous stack RAM and keeps a registered top-of-stack copy.
module stack_sequencer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned PC_W       = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  step,
    input  logic [7:0]            inst,
    input  logic [DATA_W-1:0]     imm,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [PC_W-1:0]       pc,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [DATA_W-1:0]     top_item,
    output logic                  top_valid,
    output logic [DEPTH_LOG2:0]   depth,
    output logic                  busy,
    output logic                  halted,
    output logic [1:0]            fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_POP_LOAD,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_POP   = 8'h02;
    localparam logic [7:0] OP_PUSH  = 8'h10;
    localparam logic [7:0] OP_PUSH0 = 8'h11;
    localparam logic [7:0] OP_INC   = 8'h20;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] FAULT_OVER  = 2'b01;
    localparam logic [1:0] FAULT_UNDER = 2'b10;

    state_t state;

    logic                  stack_full;
    logic                  stack_empty;
    logic [DEPTH_LOG2-1:0] push_addr;
    logic [DEPTH_LOG2-1:0] top_addr;
    logic [DEPTH_LOG2-1:0] below_addr;
    logic [DATA_W-1:0]     top_inc;

    // Address arithmetic is done modulo the RAM size; the full-depth case
    // never reaches push_addr because a push to a full stack faults.
    always_comb begin
        stack_full  = (depth == FULL);
        stack_empty = (depth == '0);
        push_addr   = depth[DEPTH_LOG2-1:0];
        top_addr    = depth[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);
        below_addr  = depth[DEPTH_LOG2-1:0] - DEPTH_LOG2'(2);
        top_inc     = top_item + DATA_W'(1);
    end

    // RAM strobes: decoded from the current opcode, only ever asserted in EXEC.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == S_EXEC) begin
            case (inst)
                OP_PUSH: begin
                    if (!stack_full) begin
                        mem_we    = 1'b1;
                        mem_addr  = push_addr;
                        mem_wdata = imm;
                    end
                end
                OP_PUSH0: begin
                    if (!stack_full) begin
                        mem_we   = 1'b1;
                        mem_addr = push_addr;
                    end
                end
                OP_INC: begin
                    if (!stack_empty) begin
                        mem_we    = 1'b1;
                        mem_addr  = top_addr;
                        mem_wdata = top_inc;
                    end
                end
                OP_POP: begin
                    if (depth > (DEPTH_LOG2+1)'(1)) begin
                        mem_re   = 1'b1;
                        mem_addr = below_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer FSM with registered architectural outputs. A pop that has to
    // reload from RAM defers its depth decrement to POP_LOAD so that depth,
    // top_item and pc all move together on the completing edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            pc        <= '0;
            depth     <= '0;
            top_item  <= '0;
            top_valid <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            fault     <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (step) begin
                        state <= S_EXEC;
                        busy  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (inst)
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        OP_PUSH, OP_PUSH0: begin
                            if (stack_full) begin
                                fault <= FAULT_OVER;
                                state <= S_FAULT;
                            end else begin
                                top_item  <= (inst == OP_PUSH) ? imm : '0;
                                depth     <= depth + (DEPTH_LOG2+1)'(1);
                                top_valid <= 1'b1;
                                pc        <= pc + ((inst == OP_PUSH) ? PC_W'(5) : PC_W'(1));
                                state     <= S_IDLE;
                                busy      <= 1'b0;
                            end
                        end
                        OP_INC: begin
                            if (stack_empty) begin
                                fault <= FAULT_UNDER;
                                state <= S_FAULT;
                            end else begin
                                top_item <= top_inc;
                                pc       <= pc + PC_W'(1);
                                state    <= S_IDLE;
                                busy     <= 1'b0;
                            end
                        end
                        OP_POP: begin
                            if (stack_empty) begin
                                fault <= FAULT_UNDER;
                                state <= S_FAULT;
                            end else if (depth == (DEPTH_LOG2+1)'(1)) begin
                                depth     <= '0;
                                top_item  <= '0;
                                top_valid <= 1'b0;
                                pc        <= pc + PC_W'(1);
                                state     <= S_IDLE;
                                busy      <= 1'b0;
                            end else begin
                                state <= S_POP_LOAD;
                            end
                        end
                        default: begin
                            pc    <= pc + PC_W'(1);
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    endcase
                end
                S_POP_LOAD: begin
                    top_item <= mem_rdata;
                    depth    <= depth - (DEPTH_LOG2+1)'(1);
                    pc       <= pc + PC_W'(1);
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                end
                S_HALT, S_FAULT: ;
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Testbench for stack_sequencer: directed program scenarios plus randomized
// programs, all checked every cycle against an instruction-level model.
module tb_stack_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned DL = 2;
    localparam int unsigned PW = 32;
    localparam int unsigned CAP = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          step = 1'b0;
    logic [7:0]    inst;
    logic [DW-1:0] imm;
    logic [DW-1:0] mem_rdata;
    logic [PW-1:0] pc;
    logic [DL-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] top_item;
    logic          top_valid;
    logic [DL:0]   depth;
    logic          busy;
    logic          halted;
    logic [1:0]    fault;

    stack_sequencer #(.DATA_W(DW), .DEPTH_LOG2(DL), .PC_W(PW)) dut (
        .CLK(CLK), .RST_N(RST_N), .step(step), .inst(inst), .imm(imm),
        .mem_rdata(mem_rdata), .pc(pc), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .top_item(top_item), .top_valid(top_valid), .depth(depth),
        .busy(busy), .halted(halted), .fault(fault)
    );

    always #5 CLK = ~CLK;

    // Instruction memory (byte addressed, wraps at 256) and stack RAM
    logic [7:0]    prog [0:255];
    logic [DW-1:0] ram  [0:CAP-1];
    logic [7:0]    pa0, pa1, pa2, pa3, pa4;
    assign pa0  = pc[7:0];
    assign pa1  = pa0 + 8'd1;
    assign pa2  = pa0 + 8'd2;
    assign pa3  = pa0 + 8'd3;
    assign pa4  = pa0 + 8'd4;
    assign inst = prog[pa0];
    assign imm  = {prog[pa1], prog[pa2], prog[pa3], prog[pa4]};

    initial begin
        for (int i = 0; i < CAP; i++) ram[i] = '0;
        mem_rdata = '0;
    end

    always @(posedge CLK) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Instruction-level model
    logic [31:0]  m_pc, m_top;
    int unsigned  m_depth;
    logic         m_halted, m_term;
    logic [1:0]   m_fault;
    logic [31:0]  m_stack [0:CAP-1];
    int unsigned  pend;
    logic         e_we, e_re;
    logic [DL-1:0] e_addr;
    logic [31:0]  e_wdata;
    logic [31:0]  n_pc, n_top;
    int unsigned  n_depth;
    logic         n_halted, n_term;
    logic [1:0]   n_fault;

    int n_err = 0;
    int n_checks = 0;

    logic          saw_we, saw_re;
    logic [DL-1:0] we_addr, re_addr;
    logic [31:0]   we_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_top = 0; m_depth = 0; m_halted = 0; m_fault = 0;
        m_term = 0; pend = 0;
        e_we = 0; e_re = 0; e_addr = '0; e_wdata = 0;
    endtask

    task automatic plan();
        logic [7:0]  op;
        logic [31:0] iv, v;
        logic [7:0]  a;
        a  = m_pc[7:0];
        op = prog[a];
        iv = {prog[8'(a + 8'd1)], prog[8'(a + 8'd2)], prog[8'(a + 8'd3)], prog[8'(a + 8'd4)]};
        n_pc = m_pc; n_top = m_top; n_depth = m_depth;
        n_halted = m_halted; n_fault = m_fault; n_term = 0;
        pend = 1;
        case (op)
            8'hFF: begin n_halted = 1; n_term = 1; end
            8'h10, 8'h11: begin
                v = (op == 8'h10) ? iv : 32'd0;
                if (m_depth == CAP) begin
                    n_fault = 2'b01; n_term = 1;
                end else begin
                    e_we = 1; e_addr = DL'(m_depth); e_wdata = v;
                    m_stack[m_depth] = v;
                    n_depth = m_depth + 1; n_top = v;
                    n_pc = m_pc + ((op == 8'h10) ? 32'd5 : 32'd1);
                end
            end
            8'h20: begin
                if (m_depth == 0) begin
                    n_fault = 2'b10; n_term = 1;
                end else begin
                    v = m_top + 32'd1;
                    e_we = 1; e_addr = DL'(m_depth - 1); e_wdata = v;
                    m_stack[m_depth - 1] = v;
                    n_top = v; n_pc = m_pc + 32'd1;
                end
            end
            8'h02: begin
                if (m_depth == 0) begin
                    n_fault = 2'b10; n_term = 1;
                end else if (m_depth == 1) begin
                    n_depth = 0; n_top = 0; n_pc = m_pc + 32'd1;
                end else begin
                    e_re = 1; e_addr = DL'(m_depth - 2);
                    n_depth = m_depth - 1; n_top = m_stack[m_depth - 2];
                    n_pc = m_pc + 32'd1;
                    pend = 2;
                end
            end
            default: n_pc = m_pc + 32'd1;
        endcase
    endtask

    task automatic model_edge();
        e_we = 0; e_re = 0; e_addr = '0; e_wdata = 0;
        if (!RST_N) begin
            model_reset();
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                m_pc = n_pc; m_top = n_top; m_depth = n_depth;
                m_halted = n_halted; m_fault = n_fault; m_term = n_term;
            end
        end else if (!m_term && step) begin
            plan();
        end
    endtask

    task automatic compare();
        chk("pc", 64'(pc), 64'(m_pc));
        chk("depth", 64'(depth), 64'(m_depth));
        chk("top_item", 64'(top_item), 64'(m_top));
        chk("top_valid", 64'(top_valid), 64'(m_depth != 0));
        chk("busy", 64'(busy), 64'((pend > 0) || m_term));
        chk("halted", 64'(halted), 64'(m_halted));
        chk("fault", 64'(fault), 64'(m_fault));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        chk("mem_re", 64'(mem_re), 64'(e_re));
        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        if (mem_we) begin saw_we = 1; we_addr = mem_addr; we_data = mem_wdata; end
        if (mem_re) begin saw_re = 1; re_addr = mem_addr; end
        compare();
    endtask

    task automatic pulse();
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        model_reset();
        #1;
        compare();
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    endtask

    task automatic put32(input int unsigned a, input logic [31:0] v);
        prog[a]     = v[31:24];
        prog[a + 1] = v[23:16];
        prog[a + 2] = v[15:8];
        prog[a + 3] = v[7:0];
    endtask

    initial begin
        saw_we = 0; saw_re = 0; we_addr = '0; re_addr = '0; we_data = 0;
        clear_prog();
        model_reset();
        #2;

        // Push 7, inc, halt; further steps have no effect
        clear_prog();
        prog[0] = 8'h10; put32(1, 32'd7); prog[5] = 8'h20; prog[6] = 8'hFF;
        do_reset();
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (3) pulse();
        chk("t1_top", 64'(top_item), 64'd8);
        chk("t1_depth", 64'(depth), 64'd1);
        chk("t1_pc", 64'(pc), 64'd6);
        chk("t1_halted", 64'(halted), 64'd1);
        repeat (2) pulse();
        chk("t1_top_hold", 64'(top_item), 64'd8);
        chk("t1_pc_hold", 64'(pc), 64'd6);

        // Push 3, push 5, pop (reload), pop (to empty)
        clear_prog();
        prog[0] = 8'h10; put32(1, 32'd3); prog[5] = 8'h10; put32(6, 32'd5);
        prog[10] = 8'h02; prog[11] = 8'h02;
        do_reset();
        repeat (2) pulse();
        saw_re = 0;
        pulse();
        chk("t2_saw_re", 64'(saw_re), 64'd1);
        chk("t2_re_addr", 64'(re_addr), 64'd0);
        chk("t2_top", 64'(top_item), 64'd3);
        chk("t2_depth", 64'(depth), 64'd1);
        saw_re = 0;
        pulse();
        chk("t2_no_re", 64'(saw_re), 64'd0);
        chk("t2_top0", 64'(top_item), 64'd0);
        chk("t2_valid0", 64'(top_valid), 64'd0);
        chk("t2_pc", 64'(pc), 64'd12);

        // Pop on empty stack faults; later steps are ignored
        clear_prog();
        prog[0] = 8'h02;
        do_reset();
        pulse();
        chk("t3_fault", 64'(fault), 64'd2);
        chk("t3_pc", 64'(pc), 64'd0);
        chk("t3_busy", 64'(busy), 64'd1);
        repeat (2) pulse();
        chk("t3_fault_hold", 64'(fault), 64'd2);
        chk("t3_pc_hold", 64'(pc), 64'd0);

        // Overflow on the fifth push
        clear_prog();
        for (int i = 0; i < 4; i++) prog[i] = 8'h11;
        prog[4] = 8'h10; put32(5, 32'h1234_5678);
        do_reset();
        repeat (4) pulse();
        saw_we = 0;
        pulse();
        chk("t4_fault", 64'(fault), 64'd1);
        chk("t4_depth", 64'(depth), 64'd4);
        chk("t4_no_we", 64'(saw_we), 64'd0);
        chk("t4_pc", 64'(pc), 64'd4);

        // Increment wraps to zero
        clear_prog();
        prog[0] = 8'h10; put32(1, 32'hFFFF_FFFF); prog[5] = 8'h20;
        do_reset();
        pulse();
        saw_we = 0;
        pulse();
        chk("t5_saw_we", 64'(saw_we), 64'd1);
        chk("t5_we_addr", 64'(we_addr), 64'd0);
        chk("t5_we_data", 64'(we_data), 64'd0);
        chk("t5_top", 64'(top_item), 64'd0);
        chk("t5_valid", 64'(top_valid), 64'd1);

        // Step during POP_LOAD is dropped
        clear_prog();
        prog[0] = 8'h11; prog[1] = 8'h11; prog[2] = 8'h02;
        do_reset();
        repeat (2) pulse();
        step = 1'b1; tick();
        step = 1'b0; tick();
        step = 1'b1; tick();
        step = 1'b0;
        repeat (2) tick();
        chk("t6_pc", 64'(pc), 64'd3);
        chk("t6_depth", 64'(depth), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);

        // Reset in the EXEC cycle of a push
        clear_prog();
        prog[0] = 8'h10; put32(1, 32'h2A);
        do_reset();
        step = 1'b1; tick();
        step = 1'b0;
        chk("t7_we_before", 64'(mem_we), 64'd1);
        RST_N = 1'b0;
        model_reset();
        #1;
        chk("t7_we_drop", 64'(mem_we), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_pc", 64'(pc), 64'd0);
        chk("t7_depth", 64'(depth), 64'd0);
        compare();
        tick();
        RST_N = 1'b1;
        repeat (2) tick();

        // Randomized programs
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 256; i++) begin
                int unsigned k;
                k = $urandom_range(0, 63);
                if (k < 16)      prog[i] = 8'h10;
                else if (k < 26) prog[i] = 8'h11;
                else if (k < 36) prog[i] = 8'h20;
                else if (k < 46) prog[i] = 8'h02;
                else if (k < 50) prog[i] = 8'h00;
                else if (k == 50) prog[i] = 8'hFF;
                else             prog[i] = 8'($urandom);
            end
            do_reset();
            for (int c = 0; c < 200; c++) begin
                step = ($urandom_range(0, 2) == 0);
                tick();
            end
            step = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Multi-cycle controller for the stack processor datapath. It fetches from the combinational instruction memory, decodes, and sequences a single-port synchronous stack RAM with no read-and-write-in-the-same-cycle hazard. It keeps a registered top-of-stack copy so the seven-segment path never shows a stale value. It advances one instruction per `step` pulse from the instruction-rate divider.

## Interface

Parameters:
- `DATA_W`, 32, stack word width
- `DEPTH_LOG2`, 8, stack RAM address width; depth = 2^DEPTH_LOG2
- `PC_W`, 32, instruction index width

Ports:
- `CLK`  in  1  system clock; all state on rising edge
- `RST_N`  in  1  reset, asynchronous and active-low
- `step`  in  1  one-cycle request to execute next instruction
- `inst`  in  8  opcode at `pc` (combinational memory)
- `imm`  in  DATA_W  32-bit constant following opcode at `pc`
- `mem_rdata`  in  DATA_W  stack RAM read data, valid the cycle after `mem_re`
- `pc`  out  PC_W  instruction index
- `mem_addr`  out  DEPTH_LOG2  stack RAM address
- `mem_wdata`  out  DATA_W  stack RAM write data
- `mem_we`  out  1  stack RAM write strobe
- `mem_re`  out  1  stack RAM read strobe
- `top_item`  out  DATA_W  current top of stack (0 when empty)
- `top_valid`  out  1  stack non-empty (feeds display `valid`)
- `depth`  out  DEPTH_LOG2+1  item count, 0..2^DEPTH_LOG2
- `busy`  out  1  FSM not in IDLE
- `halted`  out  1  halt executed
- `fault`  out  2  00 none, 01 overflow, 10 underflow

## Operation

- States: IDLE, EXEC, POP_LOAD, HALT, FAULT. `mem_*` are combinational from state and registers. All other outputs are registered.
- Item k (0 = bottom) lives at RAM address k. The top is at `depth-1`.
- IDLE: `step`=1 -> EXEC. Otherwise stay.
- EXEC decodes `inst`:
  - 0x00 nop, and any undefined opcode: `pc+=1` -> IDLE.
  - 0xFF halt: `halted`<=1, `pc` unchanged -> HALT.
  - 0x10 push imm: if `depth`==2^DEPTH_LOG2 -> FAULT, `fault`<=01. Else `mem_we`=1, `mem_addr`=`depth`, `mem_wdata`=`imm`; `top_item`<=`imm`; `depth+=1`; `pc+=5` -> IDLE.
  - 0x11 push0: same as push with value 0 and `pc+=1`.
  - 0x20 inc: if `depth`==0 -> FAULT, `fault`<=10. Else `mem_we`=1, `mem_addr`=`depth-1`, `mem_wdata`=`top_item+1` (mod 2^DATA_W); `top_item`<=`top_item+1`; `pc+=1` -> IDLE.
  - 0x02 pop: if `depth`==0 -> FAULT, `fault`<=10. Else `depth-=1`.
    - If new depth is 0: `top_item`<=0, `pc+=1` -> IDLE.
    - Else: `mem_re`=1, `mem_addr`=`depth-2` -> POP_LOAD.
- POP_LOAD: `top_item`<=`mem_rdata`; `pc+=1` -> IDLE.
- HALT and FAULT are terminal until `RST_N` asserts. `step` is ignored. `pc`, `depth`, `top_item` and `fault` hold.
- On a faulting instruction `pc`, `depth`, `top_item` are unchanged and no RAM strobe is issued.
- `top_valid` = (`depth`!=0). It updates on the same edge as `top_item`.
- `pc` wraps mod 2^PC_W. `inc` wraps 0xFFFFFFFF -> 0.
- At most one of `mem_we`/`mem_re` is high in any cycle. Both are low outside EXEC.

## Timing

- Reset (async assert, sync release): state IDLE, `pc`=0, `depth`=0, `top_item`=0, `top_valid`=0, `busy`=0, `halted`=0, `fault`=00, `mem_we`=`mem_re`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-instruction aborts it. Any strobe drops immediately. The RAM contents are not cleared, but `depth`=0 hides them.
- `step` is sampled only in IDLE. A `step` while `busy` is dropped, not queued. A `step` held high for several cycles executes one instruction per IDLE visit.
- Latency from `step` edge to result visible:
  - nop/push/push0/inc: 2 edges (IDLE->EXEC->IDLE).
  - pop to a non-empty stack: 3 edges.
  - pop to an empty stack: 2 edges.
- `top_item`, `depth`, `pc` change on the same edge, so the display never shows an intermediate value.

## Test plan

- Reset, program `10 00000007 20 FF`, pulse `step` 3 times -> `top_item`=8, `depth`=1, `pc`=6, `halted`=1. Further `step` leaves everything unchanged.
- Push 3 then push 5, then pop -> `mem_re` pulses with `mem_addr`=0, `top_item`=3 two edges later, `depth`=1. A second pop -> `top_item`=0, `top_valid`=0, no `mem_re`.
- Pop on an empty stack -> `fault`=10, FSM in FAULT, `pc` unchanged. Subsequent `step`s are ignored until reset.
- DEPTH_LOG2=2: 4x push0, then a 5th push -> `fault`=01, `depth`=4, no `mem_we` on the 5th.
- Push 0xFFFFFFFF, inc -> `top_item`=0, `mem_wdata`=0 at `mem_addr`=0, `top_valid`=1.
- Pulse `step` during POP_LOAD -> ignored, exactly one `pc` increment. Assert `RST_N` low in EXEC of a push -> `mem_we` drops immediately, all outputs return to reset values.
